// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: sequences shift/capture control of a mux-flop scan chain
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = 3
) (
    input  logic                 CK,
    input  logic                 CD,
    input  logic                 START,
    input  logic                 CAPEN,
    input  logic [CHAIN_LEN-1:0] PAT,
    input  logic                 SO,
    output logic                 SD,
    output logic                 SP,
    output logic                 SI,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] UNLOAD
);
    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, FINISH} state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt;
    logic [CHAIN_LEN-1:0] pat_q;
    logic                 capen_q;
    logic [CNT_W-1:0]     idx;
    logic                 last;

    // the chain's far end is reached first, so bits go out MSB first
    assign idx  = CNT_W'(CHAIN_LEN - 1) - cnt;
    assign last = cnt == CNT_W'(CHAIN_LEN - 1);

    assign SD   = state == SHIFT;
    assign SP   = state == SHIFT || state == CAPTURE;
    assign SI   = state == SHIFT ? pat_q[idx] : 1'b0;
    assign BUSY = state != IDLE;
    assign DONE = state == FINISH;

    // next-state decode
    always_comb begin
        state_n = state == IDLE    ? (START ? SHIFT : IDLE) :
                  state == SHIFT   ? (last ? (capen_q ? CAPTURE : FINISH) : SHIFT) :
                  state == CAPTURE ? FINISH : IDLE;
    end

    // state register plus counter, latched request and unload capture
    always_ff @(posedge CK) begin
        if (CD) begin
            state   <= IDLE;
            cnt     <= '0;
            pat_q   <= '0;
            capen_q <= 1'b0;
            UNLOAD  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && START) begin
                pat_q   <= PAT;
                capen_q <= CAPEN;
                cnt     <= '0;
            end
            if (state == SHIFT) begin
                UNLOAD[idx] <= SO;
                cnt         <= last ? '0 : cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: randomized bench with a behavioural mux-flop chain and operation model
module tb_scan_chain_ctrl;
    logic       CK = 1'b0;
    logic       CD = 1'b1;
    logic       START = 1'b0;
    logic       CAPEN = 1'b0;
    logic [7:0] PAT = 8'h00;
    logic       SO;
    logic       SD, SP, SI, BUSY, DONE;
    logic [7:0] UNLOAD;

    logic [7:0] chain_m;
    logic [7:0] d0 = 8'h00;
    logic       load_m = 1'b0;
    logic [7:0] load_v = 8'h00;
    logic       so_tog = 1'b0;
    logic       so_rand = 1'b0;
    int         errs = 0;
    int         checks = 0;

    scan_chain_ctrl #(.CHAIN_LEN(8), .CNT_W(3)) dut (
        .CK(CK), .CD(CD), .START(START), .CAPEN(CAPEN), .PAT(PAT), .SO(SO),
        .SD(SD), .SP(SP), .SI(SI), .BUSY(BUSY), .DONE(DONE), .UNLOAD(UNLOAD)
    );

    always #5 CK = ~CK;

    assign SO = so_tog ? so_rand : chain_m[7];

    // behavioural chain: D1 path shifts toward position 7, D0 path loads d0
    always @(posedge CK) begin
        if (load_m) chain_m <= load_v;
        else if (SP) chain_m <= SD ? {chain_m[6:0], SI} : d0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] v);
        load_v = v;
        load_m = 1'b1;
        @(negedge CK);
        load_m = 1'b0;
    endtask

    task automatic idle_outs(input string tag);
        check({tag, "_sd"}, SD, 0);
        check({tag, "_sp"}, SP, 0);
        check({tag, "_si"}, SI, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_done"}, DONE, 0);
    endtask

    // one full operation; expected values come from the operation's definition
    task automatic op(input logic [7:0] p, input logic ce, input logic poke);
        logic [7:0] pre;
        int n;
        pre = chain_m;
        n = 8 + 1 + int'(ce);
        START = 1'b1;
        PAT = p;
        CAPEN = ce;
        @(negedge CK);
        START = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("busy", BUSY, 1);
            check("sd", SD, i < 8);
            check("sp", SP, i < 8 || i == 8 && ce);
            check("si", SI, i < 8 ? p[7-i] : 1'b0);
            check("done", DONE, i == n - 1);
            START = poke && (i == 3 || i == n - 1);
            PAT = 8'($urandom);
            CAPEN = 1'($urandom);
            @(negedge CK);
        end
        START = 1'b0;
        check("post_busy", BUSY, 0);
        check("post_done", DONE, 0);
        check("unload", UNLOAD, pre);
        check("chain", chain_m, ce ? d0 : p);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge CK);
        idle_outs("reset");
        check("reset_unload", UNLOAD, 0);
        CD = 1'b0;
        preload(8'h00);
        op(8'hA5, 1'b0, 1'b0);
        op(8'h3C, 1'b0, 1'b0);
        d0 = 8'h5A;
        op(8'hFF, 1'b1, 1'b0);
        op(8'h00, 1'b0, 1'b0);
        op(8'($urandom), 1'($urandom), 1'b1);
        op(8'($urandom), 1'($urandom), 1'b0);
        // abort at shift step 4
        START = 1'b1;
        PAT = 8'hC3;
        CAPEN = 1'b1;
        @(negedge CK);
        START = 1'b0;
        repeat (4) @(negedge CK);
        CD = 1'b1;
        @(negedge CK);
        CD = 1'b0;
        idle_outs("abort");
        check("abort_unload", UNLOAD, 0);
        for (int i = 0; i < 12; i++) begin
            check("abort_nodone", DONE, 0);
            @(negedge CK);
        end
        // long idle with noisy inputs
        preload(8'h96);
        op(8'h69, 1'b0, 1'b0);
        so_tog = 1'b1;
        for (int i = 0; i < 20; i++) begin
            so_rand = 1'($urandom);
            PAT = 8'($urandom);
            CAPEN = 1'($urandom);
            @(negedge CK);
            idle_outs("idle");
            check("idle_unload", UNLOAD, 8'h96);
            check("idle_chain", chain_m, 8'h69);
        end
        so_tog = 1'b0;
        for (int r = 0; r < 6; r++) begin
            d0 = 8'($urandom);
            op(8'($urandom), 1'($urandom), 1'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
